// File: rtl/gray_updown_counter_pkg.sv
// Shared definitions for the Gray-code counter family: mode constants and
// binary/Gray conversion helpers reused by the counter, checkers and encoders.
package gray_updown_counter_pkg;

  // Widest counter the helpers support; callers zero-extend narrower values.
  localparam int GC_MAX_WIDTH = 16;

  // End-of-range behaviour selected by the SATURATE parameter.
  localparam int GC_WRAP = 0;  // roll over to the opposite end
  localparam int GC_SAT  = 1;  // stick at the end

  // Reflected binary Gray code of a binary index.
  function automatic logic [GC_MAX_WIDTH-1:0] bin2gray(
    input logic [GC_MAX_WIDTH-1:0] bin
  );
    return bin ^ (bin >> 1);
  endfunction

  // Binary index of a Gray code word: each bit is the XOR of all Gray bits
  // at or above it.
  function automatic logic [GC_MAX_WIDTH-1:0] gray2bin(
    input logic [GC_MAX_WIDTH-1:0] gray
  );
    logic [GC_MAX_WIDTH-1:0] bin;
    bin[GC_MAX_WIDTH-1] = gray[GC_MAX_WIDTH-1];
    for (int i = GC_MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage : gray_updown_counter_pkg

// File: rtl/gray_updown_counter_step.sv
// Combinational single-step engine for the Gray counter: given the current
// binary index and direction, produce the index after one enabled step and
// flag when that step rolls over an end of the range.
module gray_step
  import gray_updown_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SATURATE = GC_WRAP
) (
  input  logic [WIDTH-1:0] b,
  input  logic             up,
  output logic [WIDTH-1:0] next_b,
  output logic             wrap_evt
);

  localparam logic [WIDTH-1:0] B_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] B_ONE = WIDTH'(1);

  // One step up or down; at an end either roll over (wrap mode) or stay put.
  always_comb begin
    // NOTE: both outputs get a default before any branch, so every path through
    // the block assigns them and no latch can be inferred.
    next_b   = b;
    wrap_evt = 1'b0;
    if (up) begin
      if (b != B_MAX) begin
        next_b = b + B_ONE;
      end else if (SATURATE == GC_WRAP) begin
        next_b   = '0;
        wrap_evt = 1'b1;
      end
    end else begin
      if (b != '0) begin
        next_b = b - B_ONE;
      end else if (SATURATE == GC_WRAP) begin
        next_b   = B_MAX;
        wrap_evt = 1'b1;
      end
    end
  end

endmodule : gray_step

// File: rtl/gray_updown_counter.sv
// Parametrised up/down Gray-code counter with synchronous load and selectable
// wrap/saturate ends. The binary index and its Gray code are held in separate
// registers that always update together, so q and br are never skewed; the
// Gray value is always derived from the next binary index.
module gray_updown_counter
  import gray_updown_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SATURATE    = GC_WRAP,
  parameter int RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] br,
  output logic             tc,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] B_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] RST_B = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] RST_G = WIDTH'(bin2gray(GC_MAX_WIDTH'(RST_B)));

  // Reject configurations the conversion helpers or index range cannot hold.
  if (WIDTH < 2 || WIDTH > GC_MAX_WIDTH) begin : g_bad_width
    $error("gray_updown_counter: WIDTH must be in 2..16");
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= (1 << WIDTH)) begin : g_bad_reset
    $error("gray_updown_counter: RESET_VALUE out of range for WIDTH");
  end

  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_g;
  logic             r_wrapped;

  logic [WIDTH-1:0] w_step_b;
  logic             w_step_wrap;
  logic [WIDTH-1:0] w_next_b;
  logic [WIDTH-1:0] w_next_g;
  logic             w_next_wrapped;

  gray_step #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_step (
    .b        (r_b),
    .up       (up),
    .next_b   (w_step_b),
    .wrap_evt (w_step_wrap)
  );

  // Load beats an enabled step; with neither, hold and let the pulse drop.
  always_comb begin
    w_next_b       = r_b;
    w_next_wrapped = 1'b0;
    if (load) begin
      w_next_b = load_bin;
    end else if (enable) begin
      w_next_b       = w_step_b;
      w_next_wrapped = w_step_wrap;
    end
  end

  // The Gray register is fed from the same next index, keeping g == gray(b).
  assign w_next_g = WIDTH'(bin2gray(GC_MAX_WIDTH'(w_next_b)));

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clock) begin
    // NOTE: registered state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_b       <= RST_B;
      r_g       <= RST_G;
      r_wrapped <= 1'b0;
    end else begin
      r_b       <= w_next_b;
      r_g       <= w_next_g;
      r_wrapped <= w_next_wrapped;
    end
  end

  // Terminal count looks at the current direction only, not at enable.
  assign tc = (up && (r_b == B_MAX)) || (!up && (r_b == '0));

  assign q       = r_g;
  assign br      = r_b;
  assign wrapped = r_wrapped;

endmodule : gray_updown_counter

// File: tb/tb_gray_updown_counter.sv
// Directed bench for gray_updown_counter: four instances (4-bit wrap, 4-bit
// saturate, 4-bit with reset value 5, 8-bit wrap) share one clock.
module tb_gray_updown_counter;
  import gray_updown_counter_pkg::*;

  logic clk;
  int   checks   = 0;
  int   failures = 0;

  logic       w4_reset, w4_enable, w4_up, w4_load, w4_tc, w4_wrapped;
  logic [3:0] w4_load_bin, w4_q, w4_br;
  logic       s4_reset, s4_enable, s4_up, s4_load, s4_tc, s4_wrapped;
  logic [3:0] s4_load_bin, s4_q, s4_br;
  logic       r4_reset, r4_enable, r4_up, r4_load, r4_tc, r4_wrapped;
  logic [3:0] r4_load_bin, r4_q, r4_br;
  logic       w8_reset, w8_enable, w8_up, w8_load, w8_tc, w8_wrapped;
  logic [7:0] w8_load_bin, w8_q, w8_br;

  logic [3:0] gray4 [16];

  gray_updown_counter #(.WIDTH(4), .SATURATE(GC_WRAP), .RESET_VALUE(0)) u_w4 (
    .clock(clk), .reset(w4_reset), .enable(w4_enable), .up(w4_up),
    .load(w4_load), .load_bin(w4_load_bin), .q(w4_q), .br(w4_br),
    .tc(w4_tc), .wrapped(w4_wrapped));

  gray_updown_counter #(.WIDTH(4), .SATURATE(GC_SAT), .RESET_VALUE(0)) u_s4 (
    .clock(clk), .reset(s4_reset), .enable(s4_enable), .up(s4_up),
    .load(s4_load), .load_bin(s4_load_bin), .q(s4_q), .br(s4_br),
    .tc(s4_tc), .wrapped(s4_wrapped));

  gray_updown_counter #(.WIDTH(4), .SATURATE(GC_WRAP), .RESET_VALUE(5)) u_r4 (
    .clock(clk), .reset(r4_reset), .enable(r4_enable), .up(r4_up),
    .load(r4_load), .load_bin(r4_load_bin), .q(r4_q), .br(r4_br),
    .tc(r4_tc), .wrapped(r4_wrapped));

  gray_updown_counter #(.WIDTH(8), .SATURATE(GC_WRAP), .RESET_VALUE(0)) u_w8 (
    .clock(clk), .reset(w8_reset), .enable(w8_enable), .up(w8_up),
    .load(w8_load), .load_bin(w8_load_bin), .q(w8_q), .br(w8_br),
    .tc(w8_tc), .wrapped(w8_wrapped));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] prev4;
    logic [7:0] mb, nb, lb, prev8;
    logic       en, dir, ld, wr;

    gray4 = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    w4_reset = 1; w4_enable = 0; w4_up = 1; w4_load = 0; w4_load_bin = '0;
    s4_reset = 1; s4_enable = 0; s4_up = 1; s4_load = 0; s4_load_bin = '0;
    r4_reset = 1; r4_enable = 0; r4_up = 1; r4_load = 0; r4_load_bin = '0;
    w8_reset = 1; w8_enable = 0; w8_up = 1; w8_load = 0; w8_load_bin = '0;
    tick();
    w4_reset = 0; s4_reset = 0; r4_reset = 0; w8_reset = 0;

    // Reset state
    check("rst_q",        16'(w4_q),       16'h0);
    check("rst_br",       16'(w4_br),      16'h0);
    check("rst_wrapped",  16'(w4_wrapped), 16'h0);
    check("rst_tc_up",    16'(w4_tc),      16'h0);
    w4_up = 0; #1;
    check("rst_tc_down",  16'(w4_tc),      16'h1);
    w4_up = 1; #1;
    check("rv5_rst_br",   16'(r4_br),      16'h5);
    check("rv5_rst_q",    16'(r4_q),       16'h7);

    // Count up through a full cycle and the wrap
    w4_enable = 1;
    prev4 = w4_q;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("up_br_%0d", i),      16'(w4_br),      16'(i % 16));
      check($sformatf("up_q_%0d", i),       16'(w4_q),       16'(gray4[i % 16]));
      check($sformatf("up_wrapped_%0d", i), 16'(w4_wrapped), 16'(i == 16));
      check($sformatf("up_tc_%0d", i),      16'(w4_tc),      16'(i == 15));
      check($sformatf("up_onebit_%0d", i),  16'($countones(w4_q ^ prev4)), 16'h1);
      prev4 = w4_q;
    end
    w4_enable = 0;
    tick();
    check("up_wrap_pulse_end", 16'(w4_wrapped), 16'h0);
    check("up_hold_br",        16'(w4_br),      16'h0);

    // Count down from 0: wrap to 15, then 14
    w4_reset = 1; tick(); w4_reset = 0;
    w4_up = 0; w4_enable = 1;
    tick();
    check("dn_q_wrap",       16'(w4_q),       16'h8);
    check("dn_br_wrap",      16'(w4_br),      16'hF);
    check("dn_wrapped",      16'(w4_wrapped), 16'h1);
    tick();
    check("dn_q_next",       16'(w4_q),       16'h9);
    check("dn_br_next",      16'(w4_br),      16'hE);
    check("dn_wrapped_drop", 16'(w4_wrapped), 16'h0);

    // Load 9 with enable high: load wins
    w4_load = 1; w4_load_bin = 4'd9;
    tick();
    check("ld_q",       16'(w4_q),       16'hD);
    check("ld_br",      16'(w4_br),      16'h9);
    check("ld_wrapped", 16'(w4_wrapped), 16'h0);
    w4_load = 0; w4_up = 1;
    tick();
    check("ld_step_q",  16'(w4_q),       16'hF);
    check("ld_step_br", 16'(w4_br),      16'hA);
    w4_enable = 0;

    // Saturate at the top, then reverse
    s4_load = 1; s4_load_bin = 4'hF;
    tick();
    s4_load = 0; s4_up = 1; s4_enable = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sat_q_%0d", i),       16'(s4_q),       16'h8);
      check($sformatf("sat_br_%0d", i),      16'(s4_br),      16'hF);
      check($sformatf("sat_tc_%0d", i),      16'(s4_tc),      16'h1);
      check($sformatf("sat_wrapped_%0d", i), 16'(s4_wrapped), 16'h0);
    end
    s4_up = 0; #1;
    check("sat_tc_rev", 16'(s4_tc), 16'h0);
    tick();
    check("sat_rev_br", 16'(s4_br), 16'hE);
    check("sat_rev_q",  16'(s4_q),  16'h9);

    // Saturate at the bottom
    s4_load = 1; s4_load_bin = 4'h0;
    tick();
    s4_load = 0;
    tick();
    check("sat_lo_br",      16'(s4_br),      16'h0);
    check("sat_lo_q",       16'(s4_q),       16'h0);
    check("sat_lo_wrapped", 16'(s4_wrapped), 16'h0);
    check("sat_lo_tc",      16'(s4_tc),      16'h1);
    s4_enable = 0;

    // Reset mid-count at br=11 beats load and enable
    r4_enable = 1; r4_up = 1;
    repeat (6) tick();
    check("rv5_cnt_br", 16'(r4_br), 16'hB);
    check("rv5_cnt_q",  16'(r4_q),  16'hE);
    r4_reset = 1; r4_load = 1; r4_load_bin = 4'd3;
    tick();
    check("rv5_mid_br",      16'(r4_br),      16'h5);
    check("rv5_mid_q",       16'(r4_q),       16'h7);
    check("rv5_mid_wrapped", 16'(r4_wrapped), 16'h0);
    r4_reset = 0; r4_load = 0; r4_enable = 0;

    // 8-bit random run against a reference model
    mb = 8'h00;
    for (int n = 0; n < 10000; n++) begin
      en  = ($urandom_range(0, 3) != 0);
      dir = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 31) == 0);
      lb  = 8'($urandom_range(0, 255));
      w8_enable = en; w8_up = dir; w8_load = ld; w8_load_bin = lb;
      #1;
      check("w8_tc", 16'(w8_tc), 16'((dir && mb == 8'hFF) || (!dir && mb == 8'h00)));
      wr = 1'b0;
      if (ld) begin
        nb = lb;
      end else if (en) begin
        if (dir) begin
          nb = mb + 8'd1;
          wr = (mb == 8'hFF);
        end else begin
          nb = mb - 8'd1;
          wr = (mb == 8'h00);
        end
      end else begin
        nb = mb;
      end
      prev8 = w8_q;
      tick();
      mb = nb;
      check("w8_br",      16'(w8_br),      16'(mb));
      check("w8_q",       16'(w8_q),       16'(mb ^ (mb >> 1)));
      check("w8_decode",  gray2bin(16'(w8_q)), 16'(mb));
      check("w8_wrapped", 16'(w8_wrapped), 16'(wr));
      if (en && !ld) begin
        check("w8_onebit", 16'($countones(w8_q ^ prev8)), 16'h1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_gray_updown_counter
